// File: rtl/sbox_ctrl_pkg.sv
// Shared definitions for the masked S-box controllers: FSM encoding, nibble widths
// and default timing of the HPC2 S-box gating controller.
package sbox_ctrl_pkg;

  localparam int NIBBLE_W         = 4;
  localparam int FRESH_W          = 4;
  localparam int SBOX_LAT_DEFAULT = 5;
  localparam int TIMEOUT_DEFAULT  = 8;

  typedef enum logic [1:0] {
    IDLE,
    RAND,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer, which
// advances past the accepted requester when the transaction is retired.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            any_req
);

  logic [IDXW-1:0] ptr_reg;
  logic [IDXW-1:0] held_idx_reg;
  logic [NREQ-1:0] hi_mask;
  logic [NREQ-1:0] hi_req;
  logic [NREQ-1:0] pick_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign hi_mask[gi] = (IDXW'(gi) >= ptr_reg);
      assign gnt[gi]     = any_req && (gnt_idx == IDXW'(gi));
    end
  endgenerate

  // Requests at or above the pointer win; otherwise wrap to the lowest request.
  assign any_req  = |req;
  assign hi_req   = req & hi_mask;
  assign pick_vec = (|hi_req) ? hi_req : req;

  always_comb begin
    gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pick_vec[i]) gnt_idx = IDXW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg      <= '0;
      held_idx_reg <= '0;
    end else begin
      if (accept) held_idx_reg <= gnt_idx;
      if (advance) begin
        ptr_reg <= (held_idx_reg == IDXW'(NREQ - 1)) ? '0 : held_idx_reg + IDXW'(1);
      end
    end
  end

endmodule

// File: rtl/sbox_hpc2_share_arbiter.sv
// Time-shares one first-order HPC2 masked Skinny S-box between NREQ requesters:
// round-robin grant, fresh-randomness fetch, one evaluation, done pulse.
module sbox_hpc2_share_arbiter
  import sbox_ctrl_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int SBOX_LAT = SBOX_LAT_DEFAULT,
  parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NIBBLE_W*NREQ-1:0] req_x_s0,
  input  logic [NIBBLE_W*NREQ-1:0] req_x_s1,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [NIBBLE_W-1:0]      y_s0,
  output logic [NIBBLE_W-1:0]      y_s1,
  input  logic                     rnd_valid,
  input  logic [FRESH_W-1:0]       rnd_data,
  output logic                     rnd_ready,
  output logic                     sbox_rst,
  output logic [NIBBLE_W-1:0]      sbox_x_s0,
  output logic [NIBBLE_W-1:0]      sbox_x_s1,
  output logic [FRESH_W-1:0]       sbox_fresh,
  input  logic [NIBBLE_W-1:0]      sbox_y_s0,
  input  logic [NIBBLE_W-1:0]      sbox_y_s1,
  input  logic                     sbox_synch,
  output logic                     err
);

  // A timeout not longer than the S-box latency would abort every evaluation.
  localparam int TO_EFF = (TIMEOUT > SBOX_LAT) ? TIMEOUT : SBOX_LAT + 1;
  localparam int CW     = $clog2(TO_EFF);
  localparam int IDXW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              state_reg;
  logic [NREQ-1:0]     gnt_reg;
  logic [NREQ-1:0]     done_reg;
  logic [NIBBLE_W-1:0] y0_reg;
  logic [NIBBLE_W-1:0] y1_reg;
  logic [NIBBLE_W-1:0] x0_reg;
  logic [NIBBLE_W-1:0] x1_reg;
  logic [FRESH_W-1:0]  fresh_reg;
  logic                sbox_rst_reg;
  logic                err_reg;
  logic [CW-1:0]       cnt_reg;

  logic [NIBBLE_W-1:0] x0_arr [NREQ];
  logic [NIBBLE_W-1:0] x1_arr [NREQ];
  logic [NREQ-1:0]     arb_gnt;
  logic [IDXW-1:0]     arb_idx;
  logic                arb_any;
  logic                arb_accept;
  logic                arb_advance;
  logic                run_timeout;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign x0_arr[gi] = req_x_s0[gi*NIBBLE_W +: NIBBLE_W];
      assign x1_arr[gi] = req_x_s1[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

  assign arb_accept  = (state_reg == IDLE) && arb_any;
  assign arb_advance = (state_reg == DONE);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .accept  (arb_accept),
    .advance (arb_advance),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  assign run_timeout = (cnt_reg == CW'(TO_EFF - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      done_reg     <= '0;
      y0_reg       <= '0;
      y1_reg       <= '0;
      x0_reg       <= '0;
      x1_reg       <= '0;
      fresh_reg    <= '0;
      sbox_rst_reg <= 1'b1;
      err_reg      <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      done_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (arb_any) begin
            gnt_reg   <= arb_gnt;
            x0_reg    <= x0_arr[arb_idx];
            x1_reg    <= x1_arr[arb_idx];
            state_reg <= RAND;
          end
        end
        RAND: begin
          if (rnd_valid) begin
            fresh_reg    <= rnd_data;
            sbox_rst_reg <= 1'b0;
            cnt_reg      <= '0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          // Synch has priority over a timeout landing in the same cycle.
          if (sbox_synch || run_timeout) begin
            if (sbox_synch) begin
              y0_reg <= sbox_y_s0;
              y1_reg <= sbox_y_s1;
            end else begin
              err_reg <= 1'b1;
            end
            sbox_rst_reg <= 1'b1;
            x0_reg       <= '0;
            x1_reg       <= '0;
            fresh_reg    <= '0;
            done_reg     <= gnt_reg;
            state_reg    <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DONE: begin
          gnt_reg   <= '0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt        = gnt_reg;
  assign done       = done_reg;
  assign y_s0       = y0_reg;
  assign y_s1       = y1_reg;
  assign rnd_ready  = (state_reg == RAND) && rnd_valid;
  assign sbox_rst   = sbox_rst_reg;
  assign sbox_x_s0  = x0_reg;
  assign sbox_x_s1  = x1_reg;
  assign sbox_fresh = fresh_reg;
  assign err        = err_reg;

endmodule
